// File: rtl/ucode_sequencer.sv
// Microcode sequencer: expands macro instructions matched against two entry slots
// into ROM-resident micro-op sequences, freezing fetch while a sequence runs.
module ucode_sequencer #(
  parameter int unsigned UOP_W = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [UOP_W-1:0] instr_in,
  input  logic             instr_valid,
  input  logic             flush,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [UOP_W:0]   cfg_data,
  input  logic             ent_we,
  input  logic             ent_sel,
  input  logic [11:0]      ent_data,
  output logic             control,
  output logic [UOP_W-1:0] uop,
  output logic             uop_valid,
  output logic             seq_done,
  output logic             seq_err
);

  typedef enum logic [1:0] {StIdle, StSeq, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     upc_q, upc_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           ovr_q, ovr_d;
  logic [UOP_W:0] rom_q [DEPTH];
  logic           slot_en_q   [2];
  logic [6:0]     slot_op_q   [2];
  logic [3:0]     slot_addr_q [2];

  logic [6:0]     opcode;
  logic           hit0, hit1, match;
  logic [3:0]     entry;
  logic [UOP_W:0] rom_word;

  assign opcode   = instr_in[UOP_W-1 -: 7];
  assign hit0     = slot_en_q[0] && (opcode == slot_op_q[0]);
  assign hit1     = slot_en_q[1] && (opcode == slot_op_q[1]);
  assign match    = instr_valid && !flush && (hit0 || hit1);
  assign entry    = hit0 ? slot_addr_q[0] : slot_addr_q[1];
  assign rom_word = rom_q[upc_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      upc_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Configuration storage; writes land at the edge, so same-cycle reads see old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) rom_q[i] <= '0;
      for (int s = 0; s < 2; s++) begin
        slot_en_q[s]   <= 1'b0;
        slot_op_q[s]   <= '0;
        slot_addr_q[s] <= '0;
      end
    end else begin
      if (cfg_we) rom_q[cfg_addr] <= cfg_data;
      if (ent_we) begin
        slot_en_q[ent_sel]   <= ent_data[11];
        slot_op_q[ent_sel]   <= ent_data[10:4];
        slot_addr_q[ent_sel] <= ent_data[3:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    control   = 1'b0;
    uop       = '0;
    uop_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Pass-through is gated by reset so outputs are quiet while rst is low.
        uop = rst ? instr_in : '0;
        if (match) begin
          control = 1'b1;
          state_d = StSeq;
          upc_d   = entry;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end else begin
          uop_valid = rst && instr_valid && !flush;
        end
      end
      StSeq: begin
        uop       = rom_word[UOP_W-1:0];
        uop_valid = !flush;
        control   = 1'b1;
        if (flush) begin
          state_d = StIdle;
        end else begin
          upc_d = upc_q + 4'd1;
          cnt_d = cnt_q + 4'd1;
          if (rom_word[UOP_W]) begin
            state_d = StDone;
            ovr_d   = 1'b0;
          end else if (cnt_q == 4'd15) begin
            state_d = StDone;
            ovr_d   = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign seq_done = (state_q == StDone) && !ovr_q;
  assign seq_err  = (state_q == StDone) && ovr_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed literal scenarios plus randomized traffic checked
// every cycle against a queue-based model of the expected micro-op stream.
module tb_ucode_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        flush;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [32:0] cfg_data;
  logic        ent_we;
  logic        ent_sel;
  logic [11:0] ent_data;
  logic        control;
  logic [31:0] uop;
  logic        uop_valid;
  logic        seq_done;
  logic        seq_err;

  int checks   = 0;
  int failures = 0;

  ucode_sequencer #(.UOP_W(32), .DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .flush       (flush),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .ent_we      (ent_we),
    .ent_sel     (ent_sel),
    .ent_data    (ent_data),
    .control     (control),
    .uop         (uop),
    .uop_valid   (uop_valid),
    .seq_done    (seq_done),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Model: ROM and slot images, plus the pending micro-op stream of the current macro.
  logic [32:0] m_rom  [16];
  logic        m_en   [2];
  logic [6:0]  m_op   [2];
  logic [3:0]  m_addr [2];
  logic [31:0] m_q [$];
  bit          m_busy;
  bit          m_done_pend;
  bit          m_err;

  always @(negedge clk) begin
    logic        e_ctrl, e_val, e_done, e_err, e_chku;
    logic [31:0] e_uop;
    logic        h0, h1;
    int          a;
    e_ctrl = 1'b0; e_val = 1'b0; e_done = 1'b0; e_err = 1'b0; e_chku = 1'b0; e_uop = '0;
    if (!rst) begin
      e_chku = 1'b1;
      for (int i = 0; i < 16; i++) m_rom[i] = '0;
      for (int s = 0; s < 2; s++) begin m_en[s] = 1'b0; m_op[s] = '0; m_addr[s] = '0; end
      m_q.delete();
      m_busy = 0; m_done_pend = 0; m_err = 0;
    end else if (m_done_pend) begin
      e_done = !m_err;
      e_err  = m_err;
      m_done_pend = 0;
    end else if (m_busy) begin
      e_ctrl = 1'b1;
      e_val  = !flush;
      e_chku = !flush;
      e_uop  = m_q[0];
      if (flush) begin
        m_busy = 0;
        m_q.delete();
      end else begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 0;
          m_done_pend = 1;
        end
      end
    end else begin
      h0 = m_en[0] && (instr_in[31:25] == m_op[0]);
      h1 = m_en[1] && (instr_in[31:25] == m_op[1]);
      if (instr_valid && !flush && (h0 || h1)) begin
        e_ctrl = 1'b1;
        a = h0 ? int'(m_addr[0]) : int'(m_addr[1]);
        m_q.delete();
        m_err = 1;
        for (int k = 0; k < 16; k++) begin
          m_q.push_back(m_rom[a][31:0]);
          if (m_rom[a][32]) begin
            m_err = 0;
            break;
          end
          a = (a + 1) % 16;
        end
        m_busy = 1;
      end else begin
        e_val  = instr_valid && !flush;
        e_uop  = instr_in;
        e_chku = 1'b1;
      end
    end
    chk("cyc_control", {31'b0, control}, {31'b0, e_ctrl});
    chk("cyc_uop_valid", {31'b0, uop_valid}, {31'b0, e_val});
    chk("cyc_seq_done", {31'b0, seq_done}, {31'b0, e_done});
    chk("cyc_seq_err", {31'b0, seq_err}, {31'b0, e_err});
    if (e_chku) chk("cyc_uop", uop, e_uop);
    if (rst) begin
      if (cfg_we) m_rom[cfg_addr] = cfg_data;
      if (ent_we) begin
        m_en[ent_sel]   = ent_data[11];
        m_op[ent_sel]   = ent_data[10:4];
        m_addr[ent_sel] = ent_data[3:0];
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [31:0] ins, input logic fl);
    instr_valid = iv;
    instr_in    = ins;
    flush       = fl;
  endtask

  task automatic rom_wr(input logic [3:0] a, input logic last, input logic [31:0] d);
    set_in(1'b0, '0, 1'b0);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = {last, d};
    next_cyc();
    cfg_we = 1'b0;
  endtask

  task automatic ent_wr(input logic s, input logic en, input logic [6:0] op, input logic [3:0] a);
    set_in(1'b0, '0, 1'b0);
    ent_we = 1'b1; ent_sel = s; ent_data = {en, op, a};
    next_cyc();
    ent_we = 1'b0;
  endtask

  // Literal expectation sampled mid-cycle, after inputs have settled.
  task automatic pin(input string nm, input logic c, input logic v, input logic [31:0] u,
                     input logic cu, input logic d, input logic e);
    #2;
    chk({nm, "_control"}, {31'b0, control}, {31'b0, c});
    chk({nm, "_uop_valid"}, {31'b0, uop_valid}, {31'b0, v});
    chk({nm, "_seq_done"}, {31'b0, seq_done}, {31'b0, d});
    chk({nm, "_seq_err"}, {31'b0, seq_err}, {31'b0, e});
    if (cu) chk({nm, "_uop"}, uop, u);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || m_done_pend) && n < 40) begin
      set_in(1'b0, '0, 1'b0);
      next_cyc();
      n++;
    end
    chk("wait_idle_timeout", {31'b0, m_busy || m_done_pend}, 32'd0);
  endtask

  task automatic run_macro_ab(input string nm);
    set_in(1'b1, 32'hE000_0000, 1'b0);
    pin({nm, "_match"}, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b0, '0, 1'b0);
    pin({nm, "_u0"}, 1'b1, 1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
    next_cyc();
    pin({nm, "_u1"}, 1'b1, 1'b1, 32'hB, 1'b1, 1'b0, 1'b0);
    next_cyc();
    pin({nm, "_done"}, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    next_cyc();
    pin({nm, "_idle"}, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    ent_we = 1'b0; ent_sel = 1'b0; ent_data = '0;
    set_in(1'b0, '0, 1'b0);
    next_cyc();
    set_in(1'b1, 32'h1234_5678, 1'b0);
    pin("reset_quiet", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b0, '0, 1'b0);
    rst = 1'b1;
    next_cyc();

    // Basic two-uop macro.
    ent_wr(1'b0, 1'b1, 7'h70, 4'h2);
    rom_wr(4'h2, 1'b0, 32'hA);
    rom_wr(4'h3, 1'b1, 32'hB);
    run_macro_ab("basic");
    next_cyc();

    // Non-matching instruction passes straight through.
    set_in(1'b1, 32'h1234_5678, 1'b0);
    pin("passthru", 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    next_cyc();

    // Overrun: entry at 15, no last bits anywhere, wraps through all 16 words.
    for (int i = 0; i < 16; i++) rom_wr(4'(i), 1'b0, 32'h100 + i);
    ent_wr(1'b1, 1'b1, 7'h11, 4'hF);
    set_in(1'b1, 32'h2200_0000, 1'b0);
    pin("ovr_match", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b0, '0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      pin("ovr_uop", 1'b1, 1'b1, 32'h100 + ((15 + k) % 16), 1'b1, 1'b0, 1'b0);
      next_cyc();
    end
    pin("ovr_err", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    next_cyc();

    // Flush on the second sequencing cycle.
    set_in(1'b1, 32'h2200_0000, 1'b0);
    next_cyc();
    set_in(1'b0, '0, 1'b0);
    pin("flush_u0", 1'b1, 1'b1, 32'h10F, 1'b1, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b0, '0, 1'b1);
    pin("flush_cyc", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    set_in(1'b0, '0, 1'b0);
    pin("flush_after", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    pin("flush_quiet", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    next_cyc();

    // Both slots match the same opcode: slot 0 must win.
    rom_wr(4'h2, 1'b1, 32'hAA);
    rom_wr(4'h5, 1'b1, 32'h55);
    ent_wr(1'b1, 1'b1, 7'h70, 4'h5);
    set_in(1'b1, 32'hE000_0000, 1'b0);
    next_cyc();
    set_in(1'b0, '0, 1'b0);
    pin("prio_slot0", 1'b1, 1'b1, 32'hAA, 1'b1, 1'b0, 1'b0);
    next_cyc();
    pin("prio_done", 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    next_cyc();

    // Reset mid-sequence, then reprogram and replay.
    rom_wr(4'h2, 1'b0, 32'hA);
    rom_wr(4'h3, 1'b1, 32'hB);
    set_in(1'b1, 32'hE000_0000, 1'b0);
    next_cyc();
    set_in(1'b0, '0, 1'b0);
    pin("rst_u0", 1'b1, 1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
    next_cyc();
    rst = 1'b0;
    pin("rst_mid", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    next_cyc();
    pin("rst_held", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    next_cyc();
    ent_wr(1'b0, 1'b1, 7'h70, 4'h2);
    rom_wr(4'h2, 1'b0, 32'hA);
    rom_wr(4'h3, 1'b1, 32'hB);
    run_macro_ab("replay");
    next_cyc();

    // Randomized traffic, checked by the per-cycle model.
    for (int r = 0; r < 8; r++) begin
      logic [6:0] op0, op1;
      wait_idle();
      for (int i = 0; i < 16; i++)
        rom_wr(4'(i), ($urandom % 4 == 0) && (r != 3), $urandom);
      op0 = 7'($urandom);
      op1 = (r % 2 == 0) ? op0 : 7'($urandom);
      ent_wr(1'b0, ($urandom % 5 != 0), op0, 4'($urandom));
      ent_wr(1'b1, 1'b1, op1, 4'($urandom));
      for (int c = 0; c < 300; c++) begin
        logic [6:0] op;
        op = ($urandom % 2 == 0) ? (($urandom % 2 == 0) ? op0 : op1) : 7'($urandom);
        set_in(($urandom % 3 != 0), {op, 25'($urandom)},
               ($urandom % 12 == 0) && !m_done_pend);
        if ($urandom % 50 == 0) begin
          ent_we = 1'b1; ent_sel = 1'($urandom); ent_data = {1'b1, op0, 4'($urandom)};
        end
        if ($urandom % 400 == 0) rst = 1'b0;
        next_cyc();
        ent_we = 1'b0;
        rst = 1'b1;
      end
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucode_sequencer.md
UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter UOP_W, default 32: micro-op and instruction width.
REQ-003 Parameter DEPTH, default 16: micro-op ROM entries (upc 4 bits); other values unsupported.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 instr_in  input  32  instruction from fetch; opcode is bits [31:25].
REQ-007 instr_valid  input  1  instr_in valid this cycle.
REQ-008 flush  input  1  execute-stage branch redirect; aborts any sequence.
REQ-009 cfg_we  input  1  ROM write strobe.
REQ-010 cfg_addr  input  4  ROM write address.
REQ-011 cfg_data  input  33  ROM word {last, uop[31:0]}.
REQ-012 ent_we  input  1  entry-slot write strobe.
REQ-013 ent_sel  input  1  entry slot index (0/1).
REQ-014 ent_data  input  12  {en, opcode[6:0], entry_addr[3:0]}.
REQ-015 control  output  1  fetch freeze; PC holds while high.
REQ-016 uop  output  32  instruction/micro-op to decode.
REQ-017 uop_valid  output  1  uop valid.
REQ-018 seq_done  output  1  one-cycle pulse, sequence completed normally.
REQ-019 seq_err  output  1  one-cycle pulse, sequence forcibly ended without last bit.

Function
REQ-020 States SHALL be IDLE, SEQ, DONE; state, upc[3:0], cnt[3:0] registered.
REQ-021 match SHALL be instr_valid & !flush & slot enabled & instr_in[31:25]==slot opcode; slot 0 wins if both match.
REQ-022 IDLE, no match: uop = instr_in, uop_valid = instr_valid & !flush, control = 0 (combinational pass-through).
REQ-023 IDLE, match: control = 1 same cycle, uop_valid = 0 (macro op not forwarded); next state SEQ, upc <= slot entry_addr, cnt <= 0.
REQ-024 SEQ: uop = ROM[upc][31:0], uop_valid = 1, control = 1; upc <= upc+1 wrapping 15->0; cnt <= cnt+1.
REQ-025 SEQ exit: ROM[upc][32]==1 -> DONE; else cnt==15 (16th uop) -> DONE with overrun flagged.
REQ-026 DONE: one cycle, control = 0, uop_valid = 0, seq_done = 1 (or seq_err = 1 if overrun, never both); next IDLE.
REQ-027 Sequence latency: match cycle + N uop cycles + 1 DONE cycle; control high for exactly N+1 cycles.
REQ-028 flush in any state: uop_valid = 0 that cycle, next state IDLE, no seq_done/seq_err; control drops the cycle after flush.
REQ-029 flush in SEQ takes priority over the last-bit/overrun exit.
REQ-030 ROM writes accepted in any state; same-cycle write and read of one address reads old data.
REQ-031 Entry-slot writes accepted any time; take effect from the next cycle's match only.
REQ-032 seq_done/seq_err SHALL be registered-state decodes, glitch-free.

Reset
REQ-033 rst low SHALL immediately force IDLE, upc=0, cnt=0, all ROM words 0, both slots en=0.
REQ-034 During reset: control=0, uop=0, uop_valid=0, seq_done=0, seq_err=0.
REQ-035 Reset mid-sequence SHALL abort without seq_done/seq_err; first post-reset match restarts cleanly.

Verification
REQ-036 Slot0={1,7'h70,4'h2}, ROM[2]={0,32'hA}, ROM[3]={1,32'hB}; instr 0xE0000000 -> control 3 cycles, uops 0xA,0xB, seq_done pulse, uop_valid low in match and DONE cycles.
REQ-037 Non-matching instr 0x12345678 valid -> same-cycle uop 0x12345678, uop_valid=1, control=0.
REQ-038 Entry addr 4'hF, no last bits -> uops ROM[15],ROM[0..14] (16), seq_err pulse, no seq_done.
REQ-039 flush on 2nd SEQ cycle -> uop_valid=0 that cycle, control low next cycle, no done/err pulse.
REQ-040 Both slots enabled with opcode 7'h70 -> slot 0 entry used.
REQ-041 rst low during SEQ -> all outputs 0 immediately; after release, same macro replays full sequence.
